// File: rtl/pkt_tx_pkg.sv
// pkt_tx_pkg: shared types and helpers for the AXI4-Stream packet transmitter.
//   tx_state_t  - transmitter FSM states (HDR only reachable when the
//                 length-header beat is built in)
//   BEAT_BYTES  - bytes carried per 32-bit stream beat
//   last_keep() - tkeep mask for the final beat from len[1:0]
package pkt_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    DONE     = 3'd2,
    WAIT_CLR = 3'd3,
    HDR      = 3'd4
  } tx_state_t;

  localparam int BEAT_BYTES = 4;

  // A remainder of 0 means the packet length is a whole number of beats,
  // so the final beat is full.
  function automatic logic [3:0] last_keep(input logic [1:0] rem);
    case (rem)
      2'd1:    last_keep = 4'h1;
      2'd2:    last_keep = 4'h3;
      2'd3:    last_keep = 4'h7;
      default: last_keep = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/pkt_beat_mux.sv
// pkt_beat_mux: combinational 4-byte read of the packet buffer.
//   data_fifo - packet bytes, byte 0 first on the wire
//   ptr       - byte index of lane 0 (one bit wider than the buffer address)
//   len       - valid byte count; lanes at or beyond it read as zero
//   beat      - lane k = data_fifo[ptr+k], or 8'h00 when out of range
// Kept as its own module so the wide read mux stays isolated from the FSM.
module pkt_beat_mux
  import pkt_tx_pkg::*;
#(
  parameter int FIFO_ADDR_SIZE = 16
) (
  input  logic [7:0]                  data_fifo [2**FIFO_ADDR_SIZE],
  input  logic [FIFO_ADDR_SIZE:0]     ptr,
  input  logic [FIFO_ADDR_SIZE-1:0]   len,
  output logic [8*BEAT_BYTES-1:0]     beat
);

  localparam int DEPTH = 2**FIFO_ADDR_SIZE;
  localparam int IW    = FIFO_ADDR_SIZE + 2;

  generate
    for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
      logic [IW-1:0] idx;
      logic          in_range;

      // Two extra index bits so ptr+3 can never wrap back into the buffer.
      assign idx      = {1'b0, ptr} + IW'(gi);
      assign in_range = (idx < {2'b00, len}) && (idx < IW'(DEPTH));
      assign beat[8*gi +: 8] = in_range ? data_fifo[idx[FIFO_ADDR_SIZE-1:0]] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/m_axis_packet_tx.sv
// m_axis_packet_tx: streams a completed packet from the collection buffer
// out on a 32-bit AXI4-Stream master, then pulses flush to release the buffer.
//   aclk, aresetn  - clock, synchronous active-low reset
//   data_fifo      - buffered packet bytes (byte 0 first)
//   data_len       - valid byte count, latched when a packet starts
//   ready          - buffer holds a complete packet
//   flush          - one-cycle release pulse after the last beat
//   busy           - high whenever the FSM is not IDLE
//   m_axis_*       - registered AXI4-Stream master (tdata/tkeep/tvalid/tlast/tready)
// Optional feature: define PKT_TX_LEN_HEADER_EN to prepend a header beat
// carrying the packet length ({16'h0000, len[15:0]}).
module m_axis_packet_tx
  import pkt_tx_pkg::*;
#(
  parameter int FIFO_ADDR_SIZE = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [7:0]                  data_fifo [2**FIFO_ADDR_SIZE],
  input  logic [FIFO_ADDR_SIZE-1:0]   data_len,
  input  logic                        ready,
  output logic                        flush,
  output logic                        busy,
  output logic [31:0]                 m_axis_tdata,
  output logic [3:0]                  m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);

  localparam int PW = FIFO_ADDR_SIZE + 1;

  tx_state_t                 state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [FIFO_ADDR_SIZE-1:0] len_q, len_d;
  logic                      flush_q, flush_d;
  logic                      busy_q, busy_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic [3:0]                tkeep_q, tkeep_d;
  logic [31:0]               tdata_q, tdata_d;

  logic                      handshake;
  logic                      load_beat;
  logic                      load_hdr;
  logic [31:0]               mux_beat;
  logic [PW-1:0]             rem;
  logic                      last_beat;

  // The mux looks at the pointer/length about to be registered, so a new
  // beat lands in the output flops on the same edge that advances ptr.
  pkt_beat_mux #(
    .FIFO_ADDR_SIZE(FIFO_ADDR_SIZE)
  ) u_beat_mux (
    .data_fifo(data_fifo),
    .ptr      (ptr_d),
    .len      (len_d),
    .beat     (mux_beat)
  );

  assign handshake = tvalid_q && m_axis_tready;
  assign rem       = {1'b0, len_d} - ptr_d;
  assign last_beat = (rem <= PW'(BEAT_BYTES));

  // Next state, pointer and length.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    load_beat = 1'b0;
    load_hdr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready) begin
          len_d = data_len;
          ptr_d = '0;
`ifdef PKT_TX_LEN_HEADER_EN
          state_d  = HDR;
          load_hdr = 1'b1;
`else
          if (data_len == '0) begin
            state_d = DONE;
          end else begin
            state_d   = SEND;
            load_beat = 1'b1;
          end
`endif
        end
      end
      HDR: begin
        if (handshake) begin
          if (len_q == '0) begin
            state_d = DONE;
          end else begin
            state_d   = SEND;
            load_beat = 1'b1;
          end
        end
      end
      SEND: begin
        if (handshake) begin
          if (tlast_q) begin
            state_d = DONE;
          end else begin
            ptr_d     = ptr_q + PW'(BEAT_BYTES);
            load_beat = 1'b1;
          end
        end
      end
      DONE:     state_d = WAIT_CLR;
      // Hold here until the buffer drops ready, so one packet is never sent twice.
      WAIT_CLR: if (!ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Registered stream outputs: only reloaded on a new beat, so they hold
  // steady through any downstream stall.
  always_comb begin
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tkeep_d  = tkeep_q;
    tdata_d  = tdata_q;
    flush_d  = (state_d == DONE);
    busy_d   = (state_d != IDLE);
    if (load_hdr) begin
      tvalid_d = 1'b1;
      tdata_d  = '0;
`ifdef PKT_TX_LEN_HEADER_EN
      tdata_d  = {16'h0000, 16'(len_d)};
`endif
      tkeep_d  = 4'hF;
      tlast_d  = (len_d == '0);
    end else if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = mux_beat;
      tkeep_d  = last_beat ? last_keep(len_d[1:0]) : 4'hF;
      tlast_d  = last_beat;
    end else if (state_d != SEND && state_d != HDR) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tkeep_d  = '0;
      tdata_d  = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= '0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      flush_q  <= flush_d;
      busy_q   <= busy_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tkeep_q  <= tkeep_d;
      tdata_q  <= tdata_d;
    end
  end

  assign flush         = flush_q;
  assign busy          = busy_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_m_axis_packet_tx.sv
`timescale 1ns/1ps
module tb_m_axis_packet_tx;

  localparam int AW    = 5;
  localparam int DEPTH = 2**AW;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic [7:0]    fifo [DEPTH];
  logic [AW-1:0] data_len = '0;
  logic          ready    = 1'b0;
  logic          tready   = 1'b0;
  logic          flush, busy, tvalid, tlast;
  logic [31:0]   tdata;
  logic [3:0]    tkeep;

  always #5 aclk = ~aclk;

  m_axis_packet_tx #(.FIFO_ADDR_SIZE(AW)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .data_fifo    (fifo),
    .data_len     (data_len),
    .ready        (ready),
    .flush        (flush),
    .busy         (busy),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tvalid(tvalid),
    .m_axis_tlast (tlast),
    .m_axis_tready(tready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  bit    exp_flush_q[$];   // 1 = zero-length packet: no beat precedes the flush
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and flush.
  initial begin
    beat_t e;
    beat_t held;
    bit    zl;
    bit    stall = 1'b0;
    bit    prev_last_hs = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall = 1'b0;
        prev_last_hs = 1'b0;
      end else begin
        if (stall) begin
          chk("tvalid_held", tvalid, 1);
          chk("tdata_held", tdata, held.data);
          chk("tkeep_held", tkeep, held.keep);
          chk("tlast_held", tlast, held.last);
        end
        if (flush) begin
          if (exp_flush_q.size() == 0) begin
            chk("unexpected_flush", 1, 0);
          end else begin
            zl = exp_flush_q.pop_front();
            if (!zl) chk("flush_after_last", prev_last_hs, 1);
            $display("flush pulse at %0t", $time);
          end
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", tdata, e.data);
            chk("tkeep", tkeep, e.keep);
            chk("tlast", tlast, e.last);
            $display("beat tdata=%08h tkeep=%h tlast=%0d", tdata, tkeep, tlast);
          end
        end
        stall        = tvalid && !tready;
        held         = '{tdata, tkeep, tlast};
        prev_last_hs = tvalid && tready && tlast;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic fill(input int len, input int base);
    for (int i = 0; i < DEPTH; i++) fifo[i] = (i < len) ? 8'(base + i + 1) : 8'hEE;
    data_len = AW'(len);
  endtask

  task automatic push_hdr(input int len);
`ifdef PKT_TX_LEN_HEADER_EN
    exp_q.push_back('{{16'h0000, 16'(len)}, 4'hF, (len == 0)});
`else
    if (len < 0) $display("negative length %0d", len);
`endif
  endtask

  task automatic push_flush(input int len);
`ifdef PKT_TX_LEN_HEADER_EN
    exp_flush_q.push_back(1'b0);
`else
    exp_flush_q.push_back(len == 0);
`endif
  endtask

  // Expected beats built from the byte image just loaded.
  task automatic push_model(input int len);
    beat_t e;
    push_hdr(len);
    for (int b = 0; b * 4 < len; b++) begin
      e = '0;
      for (int k = 0; k < 4; k++) begin
        if (b * 4 + k < len) begin
          e.data[8*k +: 8] = fifo[b * 4 + k];
          e.keep[k] = 1'b1;
        end
      end
      e.last = (b * 4 + 4 >= len);
      exp_q.push_back(e);
    end
    push_flush(len);
  endtask

  task automatic run_until_flush(input logic [15:0] pat);
    bit seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      tready = pat[cyc % 16];
      step();
      seen = flush;
    end
    chk("flush_seen", seen, 1);
    tready = 1'b1;
  endtask

  task automatic finish_packet();
    ready = 1'b0;
    step();
    step();
    chk("busy_back_idle", busy, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) fifo[i] = 8'h00;
    repeat (3) step();
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tdata", tdata, 0);
    aresetn = 1'b1;
    step();

    // 1: len 8, two full beats
    fill(8, 0);
    push_hdr(8);
    exp_q.push_back('{32'h04030201, 4'hF, 1'b0});
    exp_q.push_back('{32'h08070605, 4'hF, 1'b1});
    push_flush(8);
    tready = 1'b1;
    ready  = 1'b1;
    step();
    chk("first_valid_latency", tvalid, 1);
    chk("busy_sending", busy, 1);
    run_until_flush(16'hFFFF);
    finish_packet();

    // 2: len 5, partial final beat
    fill(5, 0);
    push_hdr(5);
    exp_q.push_back('{32'h04030201, 4'hF, 1'b0});
    exp_q.push_back('{32'h00000005, 4'h1, 1'b1});
    push_flush(5);
    ready = 1'b1;
    run_until_flush(16'hFFFF);
    finish_packet();

    // 3: len 13 with tready toggling
    fill(13, 8'h20);
    push_model(13);
    ready = 1'b1;
    run_until_flush(16'b0110_1001_1101_0010);
    finish_packet();
    chk("t3_beats_left", exp_q.size(), 0);

    // 4: zero-length packet
    fill(0, 0);
    push_model(0);
    ready = 1'b1;
`ifdef PKT_TX_LEN_HEADER_EN
    run_until_flush(16'hFFFF);
`else
    step();
    chk("zero_len_flush", flush, 1);
    chk("zero_len_no_beat", tvalid, 0);
`endif
    finish_packet();

    // 5: ready held after flush must not resend
    fill(6, 8'h40);
    push_model(6);
    ready = 1'b1;
    run_until_flush(16'hFFFF);
    n = 0;
    repeat (10) begin
      step();
      if (tvalid || flush) n++;
    end
    chk("no_resend", n, 0);
    chk("busy_wait_clr", busy, 1);
    finish_packet();
    fill(7, 8'h50);
    push_model(7);
    ready = 1'b1;
    run_until_flush(16'hFFFF);
    finish_packet();

    // 6: reset during beat 2 of a 16-byte packet, then full resend
    fill(16, 8'h60);
    push_model(16);
    tready = 1'b1;
    ready  = 1'b1;
    step();
    step();
    chk("beat2_before_reset", tdata, 32'h68676665);
    tready  = 1'b0;
    aresetn = 1'b0;
    step();
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tdata", tdata, 0);
    chk("mid_rst_tkeep", tkeep, 0);
    chk("mid_rst_tlast", tlast, 0);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    exp_flush_q.delete();
    push_model(16);
    aresetn = 1'b1;
    tready  = 1'b1;
    run_until_flush(16'hFFFF);
    finish_packet();

    step();
    chk("beats_left", exp_q.size(), 0);
    chk("flushes_left", exp_flush_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
